// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood gear timer.
package hood_pkg;

  localparam int unsigned BcdDigitW = 4;

  // Requested-mode encodings from the mode FSM; 4..7 are treated as standby.
  localparam logic [2:0] MODE_STANDBY = 3'd0;
  localparam logic [2:0] MODE_G1      = 3'd1;
  localparam logic [2:0] MODE_G2      = 3'd2;
  localparam logic [2:0] MODE_HURR    = 3'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHurr,
    StHold
  } hood_state_e;

  // Binary seconds (0..5999) to MM:SS BCD.
  function automatic logic [4*BcdDigitW-1:0] sec_to_mmss_bcd(input logic [12:0] sec);
    int unsigned mm;
    int unsigned ss;
    mm = 32'(sec) / 32'd60;
    ss = 32'(sec) % 32'd60;
    return {4'(mm / 32'd10), 4'(mm % 32'd10), 4'(ss / 32'd10), 4'(ss % 32'd10)};
  endfunction

endpackage

// File: rtl/hood_gear_timer_if.sv
// Mode request in, gear/time/status out, between the mode FSM and the gear timer.
interface hood_gear_timer_if;
  import hood_pkg::*;

  logic [2:0]             mode_state;
  logic                   menu_btn;
  logic                   clean_done;
  logic [1:0]             fan_level;
  logic                   hurricane_active;
  logic                   hurricane_avail;
  logic                   hurricane_done;
  logic                   return_state;
  logic [6*BcdDigitW-1:0] cum_bcd;
  logic [4*BcdDigitW-1:0] cd_bcd;
  logic                   display_sel;
  logic                   clean_remind;

  modport master (
    output mode_state, menu_btn, clean_done,
    input  fan_level, hurricane_active, hurricane_avail, hurricane_done, return_state,
    input  cum_bcd, cd_bcd, display_sel, clean_remind
  );

  modport slave (
    input  mode_state, menu_btn, clean_done,
    output fan_level, hurricane_active, hurricane_avail, hurricane_done, return_state,
    output cum_bcd, cd_bcd, display_sel, clean_remind
  );

endinterface

// File: rtl/hood_bcd_clock.sv
// Cascaded BCD HH:MM:SS counter, wraps 99:59:59 -> 00:00:00.
module hood_bcd_clock import hood_pkg::*; #(
  parameter logic [6*BcdDigitW-1:0] ResetVal = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inc_i,
  output logic [6*BcdDigitW-1:0] bcd_o
);

  // Digit 0 is seconds units, digit 5 is hours tens.
  localparam logic [5:0][BcdDigitW-1:0] DigMax = {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

  logic [5:0][BcdDigitW-1:0] dig_q, dig_d;
  logic                      carry;

  // Ripple the increment through the digits, rolling each at its own limit.
  always_comb begin
    dig_d = dig_q;
    carry = inc_i;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (dig_q[i] == DigMax[i]) begin
          dig_d[i] = '0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dig_q <= ResetVal;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign bcd_o = dig_q;

endmodule

// File: rtl/hood_gear_timer.sv
// Fan-gear timing controller: cumulative run time, hurricane countdown with a
// per-reset use budget, and an optional cleaning reminder enabled by defining
// HOOD_CLEAN_REMIND_EN.
module hood_gear_timer import hood_pkg::*; #(
  parameter int unsigned      HURRICANE_SEC    = 60,
  parameter int unsigned      HURRICANE_USES   = 1,
  parameter int unsigned      CLEAN_REMIND_SEC = 36000,
  parameter logic [23:0]      CumResetBcd      = '0
) (
  input  logic              clk_1hz,
  input  logic              rst,
  hood_gear_timer_if.slave  bus
);

  localparam int unsigned    CdW     = 13;
  localparam logic [CdW-1:0] HurrSec = CdW'(HURRICANE_SEC);
  localparam logic [3:0]     HurrUse = 4'(HURRICANE_USES);

  hood_state_e    state_q, state_d, idle_state;
  logic [1:0]     fan_q, fan_d, idle_fan;
  logic [CdW-1:0] cd_q, cd_d;
  logic [3:0]     uses_q, uses_d;
  logic           armed_q, armed_d;
  logic           menu_q, menu_d;
  logic           ret_q, ret_d;
  logic           done_q, done_d;
  logic [15:0]    cd_bcd_q;
  logic           mode_hurr, enter_hurr, take_idle, cum_inc;
  logic [23:0]    cum_bcd;

  // Next-state: the IDLE/RUN decision is shared by HOLD exit and HURR abort/exit.
  always_comb begin
    state_d    = state_q;
    fan_d      = fan_q;
    cd_d       = cd_q;
    uses_d     = uses_q;
    armed_d    = armed_q;
    menu_d     = menu_q;
    ret_d      = ret_q;
    done_d     = 1'b0;
    idle_state = StIdle;
    idle_fan   = 2'd0;
    enter_hurr = 1'b0;
    take_idle  = 1'b0;
    mode_hurr  = (bus.mode_state == MODE_HURR);

    case (bus.mode_state)
      MODE_G1, MODE_G2: begin
        idle_state = StRun;
        idle_fan   = bus.mode_state[1:0];
      end
      MODE_HURR: begin
        if (armed_q && uses_q != 4'd0) begin
          idle_state = StHurr;
          idle_fan   = 2'd3;
          enter_hurr = 1'b1;
        end else begin
          // Hurricane not available: fall back to gear 2.
          idle_state = StRun;
          idle_fan   = 2'd2;
        end
      end
      default: ;
    endcase

    unique case (state_q)
      StIdle, StRun: take_idle = 1'b1;
      StHold:        take_idle = !mode_hurr;
      StHurr: begin
        if (bus.menu_btn) menu_d = 1'b1;
        // Completion takes priority over a same-tick mode change.
        if (cd_q == CdW'(1)) begin
          cd_d   = '0;
          done_d = 1'b1;
          ret_d  = !(menu_q || bus.menu_btn);
          if (mode_hurr) begin
            state_d = StHold;
            fan_d   = ret_d ? 2'd2 : 2'd0;
          end else begin
            take_idle = 1'b1;
          end
        end else if (!mode_hurr) begin
          take_idle = 1'b1;
        end else begin
          cd_d = cd_q - CdW'(1);
        end
      end
      default: ;
    endcase

    if (take_idle) begin
      state_d = idle_state;
      fan_d   = idle_fan;
      if (enter_hurr) begin
        cd_d    = HurrSec;
        uses_d  = uses_q - 4'd1;
        menu_d  = 1'b0;
        armed_d = 1'b0;
      end
    end

    if (!mode_hurr) armed_d = 1'b1;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      fan_q    <= 2'd0;
      cd_q     <= HurrSec;
      uses_q   <= HurrUse;
      armed_q  <= 1'b1;
      menu_q   <= 1'b0;
      ret_q    <= 1'b1;
      done_q   <= 1'b0;
      cd_bcd_q <= sec_to_mmss_bcd(HurrSec);
    end else begin
      state_q  <= state_d;
      fan_q    <= fan_d;
      cd_q     <= cd_d;
      uses_q   <= uses_d;
      armed_q  <= armed_d;
      menu_q   <= menu_d;
      ret_q    <= ret_d;
      done_q   <= done_d;
      cd_bcd_q <= sec_to_mmss_bcd(cd_d);
    end
  end

  // Run time accrues on every tick that ends with the fan on.
  assign cum_inc = (fan_d != 2'd0);

  hood_bcd_clock #(
    .ResetVal (CumResetBcd)
  ) u_cum_clock (
    .clk_i  (clk_1hz),
    .rst_ni (rst),
    .inc_i  (cum_inc),
    .bcd_o  (cum_bcd)
  );

`ifdef HOOD_CLEAN_REMIND_EN
  localparam logic [19:0] CleanSec = 20'(CLEAN_REMIND_SEC);

  logic [19:0] acc_q, acc_d;

  // Saturating run-time accumulator; clean_done beats any same-tick increment.
  always_comb begin
    acc_d = acc_q;
    if (bus.clean_done) begin
      acc_d = '0;
    end else if (cum_inc && acc_q != CleanSec) begin
      acc_d = acc_q + 20'd1;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.clean_remind = (acc_q == CleanSec);
`else
  logic unused_clean_done;
  assign unused_clean_done = bus.clean_done;
  assign bus.clean_remind  = 1'b0;
`endif

  assign bus.fan_level        = fan_q;
  assign bus.hurricane_active = (state_q == StHurr);
  assign bus.hurricane_avail  = (uses_q != 4'd0);
  assign bus.hurricane_done   = done_q;
  assign bus.return_state     = ret_q;
  assign bus.cum_bcd          = cum_bcd;
  assign bus.cd_bcd           = cd_bcd_q;
  assign bus.display_sel      = (state_q == StHurr);

endmodule

// File: tb/tb_hood_gear_timer.sv
// Directed bench for hood_gear_timer: dut A (5 s, 1 use), dut B (5 s, 2 uses,
// cumulative clock preset to 99:59:59).
module tb_hood_gear_timer;
  import hood_pkg::*;

`ifdef HOOD_CLEAN_REMIND_EN
  localparam bit CleanEn = 1'b1;
`else
  localparam bit CleanEn = 1'b0;
`endif

  logic clk_1hz = 1'b0;
  logic rst     = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  hood_gear_timer_if ifa ();
  hood_gear_timer_if ifb ();

  hood_gear_timer #(
    .HURRICANE_SEC    (5),
    .HURRICANE_USES   (1),
    .CLEAN_REMIND_SEC (10)
  ) u_dut_a (
    .clk_1hz (clk_1hz),
    .rst     (rst),
    .bus     (ifa.slave)
  );

  hood_gear_timer #(
    .HURRICANE_SEC    (5),
    .HURRICANE_USES   (2),
    .CLEAN_REMIND_SEC (10),
    .CumResetBcd      (24'h995959)
  ) u_dut_b (
    .clk_1hz (clk_1hz),
    .rst     (rst),
    .bus     (ifb.slave)
  );

  always #5 clk_1hz = ~clk_1hz;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk_1hz);
  endtask

  task automatic apply_reset();
    ifa.mode_state = 3'd0; ifa.menu_btn = 1'b0; ifa.clean_done = 1'b0;
    ifb.mode_state = 3'd0; ifb.menu_btn = 1'b0; ifb.clean_done = 1'b0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (ifa.fan_level !== 2'd0) begin miscompares++; $display("FAIL reset.fan got %0d want 0", ifa.fan_level); end
    vectors++; if (ifa.hurricane_active !== 1'b0) begin miscompares++; $display("FAIL reset.active got %0b want 0", ifa.hurricane_active); end
    vectors++; if (ifa.hurricane_done !== 1'b0) begin miscompares++; $display("FAIL reset.done got %0b want 0", ifa.hurricane_done); end
    vectors++; if (ifa.display_sel !== 1'b0) begin miscompares++; $display("FAIL reset.disp got %0b want 0", ifa.display_sel); end
    vectors++; if (ifa.clean_remind !== 1'b0) begin miscompares++; $display("FAIL reset.remind got %0b want 0", ifa.clean_remind); end
    vectors++; if (ifa.hurricane_avail !== 1'b1) begin miscompares++; $display("FAIL reset.avail got %0b want 1", ifa.hurricane_avail); end
    vectors++; if (ifa.return_state !== 1'b1) begin miscompares++; $display("FAIL reset.ret got %0b want 1", ifa.return_state); end
    vectors++; if (ifa.cum_bcd !== 24'h000000) begin miscompares++; $display("FAIL reset.cum got %h want 000000", ifa.cum_bcd); end
    vectors++; if (ifa.cd_bcd !== 16'h0005) begin miscompares++; $display("FAIL reset.cd got %h want 0005", ifa.cd_bcd); end
    vectors++; if (ifb.cum_bcd !== 24'h995959) begin miscompares++; $display("FAIL reset.cum_b got %h want 995959", ifb.cum_bcd); end
  endtask

  task automatic test_cum_wrap();
    ifb.mode_state = 3'd1;
    tick(1);
    vectors++; if (ifb.cum_bcd !== 24'h000000) begin miscompares++; $display("FAIL wrap.cum got %h want 000000", ifb.cum_bcd); end
    vectors++; if (ifb.fan_level !== 2'd1) begin miscompares++; $display("FAIL wrap.fan got %0d want 1", ifb.fan_level); end
    ifb.mode_state = 3'd0;
  endtask

  task automatic test_run();
    apply_reset();
    ifa.mode_state = 3'd1;
    tick(61);
    vectors++; if (ifa.cum_bcd !== 24'h000101) begin miscompares++; $display("FAIL run.cum got %h want 000101", ifa.cum_bcd); end
    vectors++; if (ifa.fan_level !== 2'd1) begin miscompares++; $display("FAIL run.fan got %0d want 1", ifa.fan_level); end
    vectors++; if (ifa.display_sel !== 1'b0) begin miscompares++; $display("FAIL run.disp got %0b want 0", ifa.display_sel); end
    vectors++; if (ifa.clean_remind !== CleanEn) begin miscompares++; $display("FAIL run.remind got %0b want %0b", ifa.clean_remind, CleanEn); end
    ifa.mode_state = 3'd2;
    tick(1);
    vectors++; if (ifa.fan_level !== 2'd2) begin miscompares++; $display("FAIL run.fan2 got %0d want 2", ifa.fan_level); end
    ifa.mode_state = 3'd6;
    tick(1);
    vectors++; if (ifa.fan_level !== 2'd0) begin miscompares++; $display("FAIL run.mode6 got %0d want 0", ifa.fan_level); end
  endtask

  task automatic test_clean();
    apply_reset();
    ifa.mode_state = 3'd1;
    tick(9);
    vectors++; if (ifa.clean_remind !== 1'b0) begin miscompares++; $display("FAIL clean.9 got %0b want 0", ifa.clean_remind); end
    tick(1);
    vectors++; if (ifa.clean_remind !== CleanEn) begin miscompares++; $display("FAIL clean.10 got %0b want %0b", ifa.clean_remind, CleanEn); end
    ifa.clean_done = 1'b1;
    tick(1);
    ifa.clean_done = 1'b0;
    vectors++; if (ifa.clean_remind !== 1'b0) begin miscompares++; $display("FAIL clean.done got %0b want 0", ifa.clean_remind); end
    tick(1);
    vectors++; if (ifa.clean_remind !== 1'b0) begin miscompares++; $display("FAIL clean.after got %0b want 0", ifa.clean_remind); end
    vectors++; if (ifa.cum_bcd !== 24'h000012) begin miscompares++; $display("FAIL clean.cum got %h want 000012", ifa.cum_bcd); end
    ifa.mode_state = 3'd0;
  endtask

  task automatic test_hurricane();
    apply_reset();
    ifa.mode_state = 3'd3;
    tick(1);
    vectors++; if (ifa.cd_bcd !== 16'h0005) begin miscompares++; $display("FAIL hurr.entry_cd got %h want 0005", ifa.cd_bcd); end
    vectors++; if (ifa.fan_level !== 2'd3) begin miscompares++; $display("FAIL hurr.fan got %0d want 3", ifa.fan_level); end
    vectors++; if (ifa.display_sel !== 1'b1) begin miscompares++; $display("FAIL hurr.disp got %0b want 1", ifa.display_sel); end
    vectors++; if (ifa.hurricane_avail !== 1'b0) begin miscompares++; $display("FAIL hurr.avail got %0b want 0", ifa.hurricane_avail); end
    for (int i = 4; i >= 1; i--) begin
      tick(1);
      vectors++; if (ifa.cd_bcd !== 16'(i)) begin miscompares++; $display("FAIL hurr.cd got %h want %h", ifa.cd_bcd, 16'(i)); end
      vectors++; if (ifa.hurricane_active !== 1'b1 || ifa.hurricane_done !== 1'b0) begin
        miscompares++; $display("FAIL hurr.run got active=%0b done=%0b want 1 0", ifa.hurricane_active, ifa.hurricane_done);
      end
    end
    tick(1);
    vectors++; if (ifa.hurricane_done !== 1'b1) begin miscompares++; $display("FAIL hurr.done got %0b want 1", ifa.hurricane_done); end
    vectors++; if (ifa.cd_bcd !== 16'h0000) begin miscompares++; $display("FAIL hurr.done_cd got %h want 0000", ifa.cd_bcd); end
    vectors++; if (ifa.return_state !== 1'b1) begin miscompares++; $display("FAIL hurr.ret got %0b want 1", ifa.return_state); end
    vectors++; if (ifa.fan_level !== 2'd2) begin miscompares++; $display("FAIL hurr.hold_fan got %0d want 2", ifa.fan_level); end
    vectors++; if (ifa.hurricane_active !== 1'b0 || ifa.display_sel !== 1'b0) begin
      miscompares++; $display("FAIL hurr.end got active=%0b disp=%0b want 0 0", ifa.hurricane_active, ifa.display_sel);
    end
    vectors++; if (ifa.cum_bcd !== 24'h000006) begin miscompares++; $display("FAIL hurr.cum got %h want 000006", ifa.cum_bcd); end
    tick(1);
    vectors++; if (ifa.hurricane_done !== 1'b0 || ifa.fan_level !== 2'd2) begin
      miscompares++; $display("FAIL hurr.hold got done=%0b fan=%0d want 0 2", ifa.hurricane_done, ifa.fan_level);
    end
  endtask

  task automatic test_menu();
    apply_reset();
    ifa.mode_state = 3'd3;
    tick(2);
    ifa.menu_btn = 1'b1;
    tick(1);
    ifa.menu_btn = 1'b0;
    vectors++; if (ifa.cd_bcd !== 16'h0003) begin miscompares++; $display("FAIL menu.cd got %h want 0003", ifa.cd_bcd); end
    tick(3);
    vectors++; if (ifa.hurricane_done !== 1'b1) begin miscompares++; $display("FAIL menu.done got %0b want 1", ifa.hurricane_done); end
    vectors++; if (ifa.return_state !== 1'b0) begin miscompares++; $display("FAIL menu.ret got %0b want 0", ifa.return_state); end
    vectors++; if (ifa.fan_level !== 2'd0) begin miscompares++; $display("FAIL menu.fan got %0d want 0", ifa.fan_level); end
    tick(1);
    vectors++; if (ifa.fan_level !== 2'd0) begin miscompares++; $display("FAIL menu.hold got %0d want 0", ifa.fan_level); end
    ifa.mode_state = 3'd0;
  endtask

  task automatic test_abort();
    apply_reset();
    ifa.mode_state = 3'd3;
    tick(4);
    vectors++; if (ifa.cd_bcd !== 16'h0002) begin miscompares++; $display("FAIL abort.pre_cd got %h want 0002", ifa.cd_bcd); end
    ifa.mode_state = 3'd1;
    tick(1);
    vectors++; if (ifa.hurricane_done !== 1'b0) begin miscompares++; $display("FAIL abort.done got %0b want 0", ifa.hurricane_done); end
    vectors++; if (ifa.fan_level !== 2'd1) begin miscompares++; $display("FAIL abort.fan got %0d want 1", ifa.fan_level); end
    vectors++; if (ifa.hurricane_active !== 1'b0) begin miscompares++; $display("FAIL abort.active got %0b want 0", ifa.hurricane_active); end
    vectors++; if (ifa.hurricane_avail !== 1'b0) begin miscompares++; $display("FAIL abort.avail got %0b want 0", ifa.hurricane_avail); end
    vectors++; if (ifa.return_state !== 1'b1) begin miscompares++; $display("FAIL abort.ret got %0b want 1", ifa.return_state); end
    ifa.mode_state = 3'd3;
    tick(1);
    vectors++; if (ifa.fan_level !== 2'd2) begin miscompares++; $display("FAIL abort.reuse got %0d want 2", ifa.fan_level); end
    ifa.mode_state = 3'd0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ifb.mode_state = 3'd3;
    tick(5);
    vectors++; if (ifb.cd_bcd !== 16'h0001) begin miscompares++; $display("FAIL b2b.cd1 got %h want 0001", ifb.cd_bcd); end
    tick(1);
    vectors++; if (ifb.hurricane_done !== 1'b1 || ifb.fan_level !== 2'd2) begin
      miscompares++; $display("FAIL b2b.done1 got done=%0b fan=%0d want 1 2", ifb.hurricane_done, ifb.fan_level);
    end
    vectors++; if (ifb.hurricane_avail !== 1'b1) begin miscompares++; $display("FAIL b2b.avail1 got %0b want 1", ifb.hurricane_avail); end
    tick(3);
    vectors++; if (ifb.hurricane_active !== 1'b0 || ifb.fan_level !== 2'd2) begin
      miscompares++; $display("FAIL b2b.hold got active=%0b fan=%0d want 0 2", ifb.hurricane_active, ifb.fan_level);
    end
    ifb.mode_state = 3'd0;
    tick(1);
    vectors++; if (ifb.fan_level !== 2'd0) begin miscompares++; $display("FAIL b2b.idle got %0d want 0", ifb.fan_level); end
    ifb.mode_state = 3'd3;
    tick(1);
    vectors++; if (ifb.hurricane_active !== 1'b1 || ifb.cd_bcd !== 16'h0005) begin
      miscompares++; $display("FAIL b2b.entry2 got active=%0b cd=%h want 1 0005", ifb.hurricane_active, ifb.cd_bcd);
    end
    vectors++; if (ifb.hurricane_avail !== 1'b0) begin miscompares++; $display("FAIL b2b.avail2 got %0b want 0", ifb.hurricane_avail); end
    tick(4);
    // Menu on the completing tick still counts.
    ifb.menu_btn = 1'b1;
    tick(1);
    ifb.menu_btn = 1'b0;
    vectors++; if (ifb.hurricane_done !== 1'b1 || ifb.return_state !== 1'b0 || ifb.fan_level !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b.done2 got done=%0b ret=%0b fan=%0d want 1 0 0", ifb.hurricane_done, ifb.return_state, ifb.fan_level);
    end
    ifb.mode_state = 3'd0;
    tick(1);
    ifb.mode_state = 3'd3;
    tick(1);
    vectors++; if (ifb.fan_level !== 2'd2 || ifb.hurricane_active !== 1'b0 || ifb.display_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b.third got fan=%0d active=%0b disp=%0b want 2 0 0", ifb.fan_level, ifb.hurricane_active, ifb.display_sel);
    end
  endtask

  task automatic test_reset_mid_hurr();
    ifa.mode_state = 3'd3;
    tick(2);
    vectors++; if (ifa.hurricane_active !== 1'b1) begin miscompares++; $display("FAIL rmid.pre got %0b want 1", ifa.hurricane_active); end
    rst = 1'b0;
    #1;
    vectors++; if (ifa.fan_level !== 2'd0 || ifa.hurricane_active !== 1'b0 || ifa.display_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid.a got fan=%0d active=%0b disp=%0b want 0 0 0", ifa.fan_level, ifa.hurricane_active, ifa.display_sel);
    end
    vectors++; if (ifa.hurricane_avail !== 1'b1 || ifa.cd_bcd !== 16'h0005 || ifa.cum_bcd !== 24'h000000) begin
      miscompares++;
      $display("FAIL rmid.a_vals got avail=%0b cd=%h cum=%h want 1 0005 000000", ifa.hurricane_avail, ifa.cd_bcd, ifa.cum_bcd);
    end
    vectors++; if (ifb.return_state !== 1'b1 || ifb.hurricane_avail !== 1'b1 || ifb.fan_level !== 2'd0) begin
      miscompares++;
      $display("FAIL rmid.b got ret=%0b avail=%0b fan=%0d want 1 1 0", ifb.return_state, ifb.hurricane_avail, ifb.fan_level);
    end
    ifa.mode_state = 3'd0;
    ifb.mode_state = 3'd0;
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_cum_wrap();
    test_run();
    test_clean();
    test_hurricane();
    test_menu();
    test_abort();
    test_back_to_back();
    test_reset_mid_hurr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hood_gear_timer.md
# hood_gear_timer

Parametrised fan-gear timing controller for the range-hood design, clocked by the 1 Hz tick domain. It tracks cumulative run time in HH:MM:SS BCD and runs a configurable hurricane (gear 3) countdown with a per-power-cycle use budget. It adds an optional cleaning-reminder accumulator. Outputs are BCD time fields and status flags consumed by the mode FSM and the display mux.

## Interface
- HURRICANE_SEC, 60, hurricane duration in seconds; legal range 1..5999.
- HURRICANE_USES, 1, hurricane activations allowed per reset; legal range 0..15.
- CLEAN_REMIND_SEC, 36000, cumulative run seconds before clean_remind asserts; legal range 1..2^20-1.
- clk_1hz  in  1  1 Hz clock.
- rst  in  1  reset, asynchronous, active-low.
- mode_state  in  3  requested mode: 0 standby, 1 gear 1, 2 gear 2, 3 hurricane, 4..7 treated as standby.
- menu_btn  in  1  level input, sampled each tick.
- clean_done  in  1  single-tick pulse that clears the reminder.
- fan_level  out  2  applied gear: 0, 1, 2 or 3.
- hurricane_active  out  1  high while the countdown runs.
- hurricane_avail  out  1  high while uses_left > 0.
- hurricane_done  out  1  one-tick pulse when a countdown completes.
- return_state  out  1  post-hurricane target: 0 standby, 1 gear 2.
- cum_bcd  out  24  cumulative time as HH,MM,SS, 4 bits per digit.
- cd_bcd  out  16  countdown remaining as MM,SS.
- display_sel  out  1  0 selects cumulative time, 1 selects countdown.
- clean_remind  out  1  cleaning reminder.

## Operation
- FSM states: IDLE (fan_level 0), RUN (fan_level = mode_state), HURR (fan_level 3), HOLD (fan_level = return_state ? 2 : 0).
- From IDLE or RUN:
  - mode 3 with armed=1 and uses_left>0 → HURR. On entry: load cd=HURRICANE_SEC, decrement uses_left, clear menu_latched.
  - mode 3 with uses_left=0 → RUN with fan_level 2.
  - mode 1 or 2 → RUN.
  - Any other mode → IDLE.
- armed clears on HURR entry. It sets on any tick where mode_state≠3.
- HURR:
  - Each tick, menu_btn=1 sets menu_latched.
  - If cd=1: cd←0, pulse hurricane_done, return_state←!menu_latched (menu_btn on this same tick counts), go to HOLD.
  - Else cd←cd−1.
  - If mode_state leaves 3 before completion: abort. Go to IDLE or RUN per the new mode. No done pulse. The use stays consumed. return_state is unchanged.
- HOLD: remain while mode_state=3. Otherwise evaluate as from IDLE.
- Cumulative counter: increments on every tick where the registered fan_level≠0. Counts 00:00:00..99:59:59, then wraps to 00:00:00.
- display_sel = 1 only in HURR.
- Completion and mode change on the same tick: completion wins (done pulse, HOLD is skipped if mode≠3).

## Timing
- All outputs are registered and update on the rising edge of clk_1hz. Mode-to-fan_level latency is 1 tick.
- Hurricane is active for exactly HURRICANE_SEC ticks. cd_bcd shows HURRICANE_SEC on the entry tick and 00:00 on the done tick.
- Reset values:
  - fan_level 0, hurricane_active 0, hurricane_done 0, display_sel 0, clean_remind 0.
  - hurricane_avail = (HURRICANE_USES>0).
  - return_state 1.
  - cum_bcd 0.
  - cd_bcd = HURRICANE_SEC in BCD.
  - uses_left = HURRICANE_USES, armed 1.
- Reset asserted mid-hurricane aborts the countdown and restores the full use budget.

## Configuration
- HOOD_CLEAN_REMIND_EN defined:
  - A 20-bit accumulator counts ticks with fan_level≠0 and saturates at CLEAN_REMIND_SEC.
  - clean_remind = (acc == CLEAN_REMIND_SEC).
  - clean_done clears acc to 0. It wins over an increment or threshold hit on the same tick.
- Undefined: the accumulator is removed, clean_remind is tied 0, and clean_done is ignored.

## Structure
- Package hood_pkg holds:
  - Mode encodings: MODE_STANDBY, MODE_G1, MODE_G2, MODE_HURR.
  - FSM state enum: IDLE, RUN, HURR, HOLD.
  - BCD digit width constant.
- One sub-module, hood_bcd_clock: a cascaded BCD SS/MM/HH counter with an increment enable and wrap at 99:59:59. It is instantiated once for cum_bcd.
- The countdown is kept in binary and converted to BCD MM:SS combinationally into the output register.

## Test plan
- Reset, then mode 1 for 61 ticks → cum_bcd 00:01:01, fan_level 1, display_sel 0.
- HURRICANE_SEC=5, mode 3 held → cd_bcd 00:05..00:01, hurricane_done on the 5th tick, return_state 1, fan_level 2 in HOLD, hurricane_avail 0.
- Same setup with menu_btn on tick 3 → return_state 0, fan_level 0 in HOLD.
- HURRICANE_USES=2: complete once, hold mode 3 → no re-entry. Mode 0 for one tick, then mode 3 → second countdown runs. Third request → fan_level 2.
- Mode 3→1 at cd=2 → no done pulse, fan_level 1, avail reflects the consumed use. Reset mid-HURR → all reset values.
- With HOOD_CLEAN_REMIND_EN and CLEAN_REMIND_SEC=10: 10 run ticks → clean_remind 1. clean_done → 0 on the next tick. Cum wrap: preload 99:59:59, one tick → 00:00:00.
